// File: rtl/neureka_tcdm_splitter.sv
// -----------------------------------------------------------------------------
// neureka_tcdm_splitter
//
// Splits one wide HCI streamer request into MP narrow 32-bit TCDM requests.
// Each narrow port may be granted in its own cycle. A grant mask remembers the
// ports already served, and the wide grant fires in the cycle the last missing
// port is granted. Read/write acknowledgements are collected in one small FIFO
// per port. A single realigned wide response is released only when every port
// FIFO holds a word.
//
// Parameters:
//   BW        wide data width in bits (multiple of 32)
//   MP        number of narrow ports (BW/32)
//   RSP_DEPTH wide transactions allowed in flight; also the per-port FIFO depth
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous return to reset state (only while idle)
//   in_req/in_gnt          wide request handshake
//   in_add/in_wen/in_be    wide address (word aligned), 1=read, byte enables
//   in_data                wide write data
//   in_r_data/in_r_valid   realigned wide response, no back-pressure
//   tcdm_req/tcdm_gnt      per-port request handshake
//   tcdm_add/wen/be/data   per-port payload, combinational from the wide inputs
//   tcdm_r_data/r_valid    per-port response
//   busy_o                 transaction or response still pending
//   err_o                  sticky: response arrived at a full port FIFO
//
// Build option:
//   NEUREKA_TCDM_SPLIT_RSP_REG_EN  registers in_r_valid/in_r_data (+1 latency).
// -----------------------------------------------------------------------------
module neureka_tcdm_splitter #(
    parameter int unsigned BW        = 128,
    parameter int unsigned MP        = BW / 32,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              in_req,
    output logic              in_gnt,
    input  logic [31:0]       in_add,
    input  logic              in_wen,
    input  logic [BW/8-1:0]   in_be,
    input  logic [BW-1:0]     in_data,
    output logic [BW-1:0]     in_r_data,
    output logic              in_r_valid,
    output logic [MP-1:0]     tcdm_req,
    input  logic [MP-1:0]     tcdm_gnt,
    output logic [MP*32-1:0]  tcdm_add,
    output logic [MP-1:0]     tcdm_wen,
    output logic [MP*4-1:0]   tcdm_be,
    output logic [MP*32-1:0]  tcdm_data,
    input  logic [MP*32-1:0]  tcdm_r_data,
    input  logic [MP-1:0]     tcdm_r_valid,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [MP-1:0]    r_granted_q;
    logic [CNT_W-1:0] r_outstanding;
    logic             r_err;

    logic [31:0]      r_mem   [MP][RSP_DEPTH];
    logic [PTR_W-1:0] r_wptr  [MP];
    logic [PTR_W-1:0] r_rptr  [MP];
    logic [CNT_W-1:0] r_count [MP];

    logic             w_stall;
    logic             w_in_gnt;
    logic             w_all_valid;
    logic             w_pop;
    logic [MP-1:0]    w_new_gnt;
    logic [MP-1:0]    w_nonempty;
    logic [MP-1:0]    w_full;
    logic [MP-1:0]    w_push;
    logic [BW-1:0]    w_heads;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------------------------------------------------------- payload
    // The payload is not latched: the initiator holds it stable until in_gnt.
    assign tcdm_wen  = {MP{in_wen}};
    assign tcdm_be   = in_be;
    assign tcdm_data = in_data;

    always_comb begin
        // NOTE: every signal driven here gets a value on every path; otherwise a latch is inferred.
        tcdm_add = '0;
        for (int ii = 0; ii < MP; ii++) begin
            tcdm_add[32*ii +: 32] = in_add + 32'(4 * ii);  // wraps at 2^32
        end
    end

    // ---------------------------------------------------------- request side
    // Only a fresh transaction is stalled; one that has started granting
    // already owns a response slot.
    assign w_stall   = (r_outstanding == CNT_W'(RSP_DEPTH)) && (r_granted_q == '0);
    assign tcdm_req  = {MP{in_req & ~w_stall}} & ~r_granted_q;
    assign w_new_gnt = tcdm_gnt & tcdm_req;
    assign w_in_gnt  = in_req & ~w_stall & (&(r_granted_q | w_new_gnt));
    assign in_gnt    = w_in_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state registers use non-blocking (<=) so all flops update from pre-edge values.
        if (!rst_ni) begin
            r_granted_q   <= '0;
            r_outstanding <= '0;
        end else if (clear_i) begin
            r_granted_q   <= '0;
            r_outstanding <= '0;
        end else begin
            r_granted_q <= w_in_gnt ? '0 : (r_granted_q | w_new_gnt);
            case ({w_in_gnt, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // --------------------------------------------------------- response FIFOs
    always_comb begin
        w_nonempty = '0;
        w_full     = '0;
        w_heads    = '0;
        for (int ii = 0; ii < MP; ii++) begin
            w_nonempty[ii]        = (r_count[ii] != '0);
            w_full[ii]            = (r_count[ii] == CNT_W'(RSP_DEPTH));
            w_heads[32*ii +: 32]  = r_mem[ii][r_rptr[ii]];
        end
    end

    assign w_all_valid = &w_nonempty;
    assign w_pop       = w_all_valid;
    // A push into a full FIFO only survives if the same cycle pops it.
    assign w_push      = tcdm_r_valid & ~(w_full & {MP{~w_pop}});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
            for (int ii = 0; ii < MP; ii++) begin
                r_wptr[ii]  <= '0;
                r_rptr[ii]  <= '0;
                r_count[ii] <= '0;
            end
        end else if (clear_i) begin
            r_err <= 1'b0;
            for (int ii = 0; ii < MP; ii++) begin
                r_wptr[ii]  <= '0;
                r_rptr[ii]  <= '0;
                r_count[ii] <= '0;
            end
        end else begin
            if (|(tcdm_r_valid & ~w_push)) begin
                r_err <= 1'b1;
            end
            for (int ii = 0; ii < MP; ii++) begin
                if (w_push[ii]) begin
                    r_wptr[ii] <= next_ptr(r_wptr[ii]);
                end
                if (w_pop) begin
                    r_rptr[ii] <= next_ptr(r_rptr[ii]);
                end
                r_count[ii] <= r_count[ii] + CNT_W'(w_push[ii]) - CNT_W'(w_pop);
            end
        end
    end

    // NOTE: the FIFO storage has no reset; the occupancy counters alone decide validity.
    always_ff @(posedge clk_i) begin
        for (int ii = 0; ii < MP; ii++) begin
            if (w_push[ii]) begin
                r_mem[ii][r_wptr[ii]] <= tcdm_r_data[32*ii +: 32];
            end
        end
    end

    // ---------------------------------------------------------- response out
`ifdef NEUREKA_TCDM_SPLIT_RSP_REG_EN
    logic          r_rsp_valid;
    logic [BW-1:0] r_rsp_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else if (clear_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= w_pop;
            if (w_pop) begin
                r_rsp_data <= w_heads;
            end
        end
    end

    assign in_r_valid = r_rsp_valid;
    assign in_r_data  = r_rsp_data;
`else
    assign in_r_valid = w_all_valid;
    assign in_r_data  = w_all_valid ? w_heads : '0;
`endif

    assign busy_o = (r_outstanding != '0) | (|r_granted_q) | (|w_nonempty);
    assign err_o  = r_err;

endmodule

// File: tb/tb_neureka_tcdm_splitter.sv
// -----------------------------------------------------------------------------
// Directed testbench for neureka_tcdm_splitter (BW=128, MP=4, RSP_DEPTH=2),
// default build with the combinational response path.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_neureka_tcdm_splitter;

    localparam int BW        = 128;
    localparam int MP        = 4;
    localparam int RSP_DEPTH = 2;

    logic            clk_i        = 1'b0;
    logic            rst_ni       = 1'b0;
    logic            clear_i      = 1'b0;
    logic            in_req       = 1'b0;
    logic [31:0]     in_add       = '0;
    logic            in_wen       = 1'b1;
    logic [15:0]     in_be        = '0;
    logic [127:0]    in_data      = '0;
    logic [3:0]      tcdm_gnt     = '0;
    logic [127:0]    tcdm_r_data  = '0;
    logic [3:0]      tcdm_r_valid = '0;

    logic            in_gnt;
    logic [127:0]    in_r_data;
    logic            in_r_valid;
    logic [3:0]      tcdm_req;
    logic [127:0]    tcdm_add;
    logic [3:0]      tcdm_wen;
    logic [15:0]     tcdm_be;
    logic [127:0]    tcdm_data;
    logic            busy_o;
    logic            err_o;

    int n_vec = 0;
    int n_err = 0;

    neureka_tcdm_splitter #(
        .BW        (BW),
        .MP        (MP),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .in_req       (in_req),
        .in_gnt       (in_gnt),
        .in_add       (in_add),
        .in_wen       (in_wen),
        .in_be        (in_be),
        .in_data      (in_data),
        .in_r_data    (in_r_data),
        .in_r_valid   (in_r_valid),
        .tcdm_req     (tcdm_req),
        .tcdm_gnt     (tcdm_gnt),
        .tcdm_add     (tcdm_add),
        .tcdm_wen     (tcdm_wen),
        .tcdm_be      (tcdm_be),
        .tcdm_data    (tcdm_data),
        .tcdm_r_data  (tcdm_r_data),
        .tcdm_r_valid (tcdm_r_valid),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        #1;
        n_vec++; if (in_gnt !== 1'b0) begin n_err++; $display("FAIL reset_in_gnt: got %b want 0", in_gnt); end
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL reset_in_r_valid: got %b want 0", in_r_valid); end
        n_vec++; if (tcdm_req !== 4'h0) begin n_err++; $display("FAIL reset_tcdm_req: got %h want 0", tcdm_req); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_o); end
        n_vec++; if (in_r_data !== 128'h0) begin n_err++; $display("FAIL reset_r_data: got %h want 0", in_r_data); end
        rst_ni = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_all_grant();
        tick();
        in_req = 1'b1; in_wen = 1'b1; in_add = 32'h0000_1000; tcdm_gnt = 4'hF;
        #1;
        n_vec++; if (tcdm_add !== {32'h100C, 32'h1008, 32'h1004, 32'h1000}) begin n_err++; $display("FAIL all_add: got %h want 100C_1008_1004_1000", tcdm_add); end
        n_vec++; if (tcdm_req !== 4'hF) begin n_err++; $display("FAIL all_req: got %h want f", tcdm_req); end
        n_vec++; if (tcdm_wen !== 4'hF) begin n_err++; $display("FAIL all_wen: got %h want f", tcdm_wen); end
        n_vec++; if (in_gnt !== 1'b1) begin n_err++; $display("FAIL all_gnt_c0: got %b want 1", in_gnt); end
        tick();
        in_req = 1'b0; tcdm_gnt = 4'h0; tcdm_r_valid = 4'hF;
        tcdm_r_data = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        #1;
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL all_rvalid_c1: got %b want 0", in_r_valid); end
        tick();
        tcdm_r_valid = 4'h0;
        #1;
        n_vec++; if (in_r_valid !== 1'b1) begin n_err++; $display("FAIL all_rvalid_c2: got %b want 1", in_r_valid); end
        n_vec++; if (in_r_data !== {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}) begin n_err++; $display("FAIL all_rdata: got %h want dddd0003_cccc0002_bbbb0001_aaaa0000", in_r_data); end
        tick();
        #1;
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL all_rvalid_c3: got %b want 0", in_r_valid); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL all_busy_end: got %b want 0", busy_o); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_staggered();
        tick();
        in_req = 1'b1; in_wen = 1'b1; in_add = 32'h0000_2000; tcdm_gnt = 4'b0101;
        tcdm_r_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0A00};
        #1;
        n_vec++; if (tcdm_req !== 4'b1111) begin n_err++; $display("FAIL stag_req_c0: got %b want 1111", tcdm_req); end
        n_vec++; if (in_gnt !== 1'b0) begin n_err++; $display("FAIL stag_gnt_c0: got %b want 0", in_gnt); end
        tick();
        tcdm_gnt = 4'b0010; tcdm_r_valid = 4'b0101;
        #1;
        n_vec++; if (tcdm_req !== 4'b1010) begin n_err++; $display("FAIL stag_req_c1: got %b want 1010", tcdm_req); end
        n_vec++; if (in_gnt !== 1'b0) begin n_err++; $display("FAIL stag_gnt_c1: got %b want 0", in_gnt); end
        tick();
        tcdm_gnt = 4'b0000; tcdm_r_valid = 4'b0010;
        #1;
        n_vec++; if (tcdm_req !== 4'b1000) begin n_err++; $display("FAIL stag_req_c2: got %b want 1000", tcdm_req); end
        n_vec++; if (in_gnt !== 1'b0) begin n_err++; $display("FAIL stag_gnt_c2: got %b want 0", in_gnt); end
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL stag_rvalid_c2: got %b want 0", in_r_valid); end
        tick();
        tcdm_gnt = 4'b1000; tcdm_r_valid = 4'b0000;
        #1;
        n_vec++; if (tcdm_req !== 4'b1000) begin n_err++; $display("FAIL stag_req_c3: got %b want 1000", tcdm_req); end
        n_vec++; if (in_gnt !== 1'b1) begin n_err++; $display("FAIL stag_gnt_c3: got %b want 1", in_gnt); end
        tick();
        in_req = 1'b0; tcdm_gnt = 4'b0000; tcdm_r_valid = 4'b1000;
        #1;
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL stag_rvalid_c4: got %b want 0", in_r_valid); end
        n_vec++; if (tcdm_req !== 4'b0000) begin n_err++; $display("FAIL stag_req_c4: got %b want 0000", tcdm_req); end
        tick();
        tcdm_r_valid = 4'b0000;
        #1;
        n_vec++; if (in_r_valid !== 1'b1) begin n_err++; $display("FAIL stag_rvalid_c5: got %b want 1", in_r_valid); end
        n_vec++; if (in_r_data !== {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_0A00}) begin n_err++; $display("FAIL stag_rdata: got %h want 33330003_22220002_11110001_00000a00", in_r_data); end
        tick();
        #1;
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL stag_rvalid_c6: got %b want 0", in_r_valid); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL stag_busy_end: got %b want 0", busy_o); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_back_to_back_stall();
        tick();
        in_req = 1'b1; in_wen = 1'b1; in_add = 32'h0000_3000; tcdm_gnt = 4'hF;
        #1;
        n_vec++; if (in_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt_t1: got %b want 1", in_gnt); end
        tick();
        in_add = 32'h0000_3010;
        #1;
        n_vec++; if (in_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt_t2: got %b want 1", in_gnt); end
        tick();
        in_add = 32'h0000_3020;
        #1;
        n_vec++; if (tcdm_req !== 4'h0) begin n_err++; $display("FAIL b2b_stall_req: got %h want 0", tcdm_req); end
        n_vec++; if (in_gnt !== 1'b0) begin n_err++; $display("FAIL b2b_stall_gnt: got %b want 0", in_gnt); end
        tick();
        #1;
        n_vec++; if (tcdm_req !== 4'h0) begin n_err++; $display("FAIL b2b_stall_req2: got %h want 0", tcdm_req); end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy_o); end
        tick();
        tcdm_r_valid = 4'hF; tcdm_r_data = {4{32'hA5A5_0001}};
        #1;
        n_vec++; if (tcdm_req !== 4'h0) begin n_err++; $display("FAIL b2b_stall_req3: got %h want 0", tcdm_req); end
        tick();
        tcdm_r_valid = 4'h0;
        #1;
        n_vec++; if (in_r_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rvalid_a: got %b want 1", in_r_valid); end
        n_vec++; if (in_r_data !== {4{32'hA5A5_0001}}) begin n_err++; $display("FAIL b2b_rdata_a: got %h want a5a50001 x4", in_r_data); end
        n_vec++; if (in_gnt !== 1'b0) begin n_err++; $display("FAIL b2b_gnt_at_pop: got %b want 0", in_gnt); end
        tick();
        #1;
        n_vec++; if (tcdm_req !== 4'hF) begin n_err++; $display("FAIL b2b_req_resume: got %h want f", tcdm_req); end
        n_vec++; if (in_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt_t3: got %b want 1", in_gnt); end
        tick();
        in_req = 1'b0; tcdm_gnt = 4'h0; tcdm_r_valid = 4'hF; tcdm_r_data = {4{32'hB6B6_0002}};
        #1;
        tick();
        tcdm_r_valid = 4'hF; tcdm_r_data = {4{32'hC7C7_0003}};
        #1;
        n_vec++; if (in_r_valid !== 1'b1) begin n_err++; $display("FAIL b2b_rvalid_b: got %b want 1", in_r_valid); end
        n_vec++; if (in_r_data !== {4{32'hB6B6_0002}}) begin n_err++; $display("FAIL b2b_rdata_b: got %h want b6b60002 x4", in_r_data); end
        tick();
        tcdm_r_valid = 4'h0;
        #1;
        n_vec++; if (in_r_data !== {4{32'hC7C7_0003}}) begin n_err++; $display("FAIL b2b_rdata_c: got %h want c7c70003 x4", in_r_data); end
        tick();
        #1;
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b want 0", busy_o); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_addr_wrap();
        tick();
        in_req = 1'b0; in_add = 32'hFFFF_FFF8;
        #1;
        n_vec++; if (tcdm_add !== {32'h0000_0004, 32'h0000_0000, 32'hFFFF_FFFC, 32'hFFFF_FFF8}) begin n_err++; $display("FAIL wrap_add: got %h want 00000004_00000000_fffffffc_fffffff8", tcdm_add); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_write();
        tick();
        in_req = 1'b1; in_wen = 1'b0; in_add = 32'h0000_4000; in_be = 16'h00F0;
        in_data = 128'h4444_4444_3333_3333_2222_2222_1111_1111; tcdm_gnt = 4'hF;
        #1;
        n_vec++; if (tcdm_be !== 16'h00F0) begin n_err++; $display("FAIL wr_be: got %h want 00f0", tcdm_be); end
        n_vec++; if (tcdm_wen !== 4'h0) begin n_err++; $display("FAIL wr_wen: got %h want 0", tcdm_wen); end
        n_vec++; if (tcdm_data !== 128'h4444_4444_3333_3333_2222_2222_1111_1111) begin n_err++; $display("FAIL wr_data: got %h want 44444444_33333333_22222222_11111111", tcdm_data); end
        n_vec++; if (in_gnt !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got %b want 1", in_gnt); end
        tick();
        in_req = 1'b0; in_wen = 1'b1; tcdm_gnt = 4'h0; tcdm_r_valid = 4'b0011;
        #1;
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL wr_rvalid_c1: got %b want 0", in_r_valid); end
        tick();
        tcdm_r_valid = 4'b1100;
        #1;
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL wr_rvalid_c2: got %b want 0", in_r_valid); end
        tick();
        tcdm_r_valid = 4'b0000;
        #1;
        n_vec++; if (in_r_valid !== 1'b1) begin n_err++; $display("FAIL wr_rvalid_c3: got %b want 1", in_r_valid); end
        tick();
        #1;
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL wr_rvalid_c4: got %b want 0", in_r_valid); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL wr_busy_end: got %b want 0", busy_o); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_overflow_clear();
        tick();
        tcdm_r_valid = 4'b0010;
        tick();
        tick();
        #1;
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL ovf_err_before: got %b want 0", err_o); end
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL ovf_busy: got %b want 1", busy_o); end
        tick();
        tcdm_r_valid = 4'b0000;
        #1;
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL ovf_err_set: got %b want 1", err_o); end
        tick();
        #1;
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL ovf_err_sticky: got %b want 1", err_o); end
        n_vec++; if (in_r_valid !== 1'b0) begin n_err++; $display("FAIL ovf_rvalid: got %b want 0", in_r_valid); end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        #1;
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL clr_err: got %b want 0", err_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b want 0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_all_grant();
        test_staggered();
        test_back_to_back_stall();
        test_addr_wrap();
        test_write();
        test_overflow_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
